move_sequencer: RTL and testbench

- Timed command sequencer in front of the movement FSM; drives its 4-bit movement_sel.
- Arbitrates two requesters: manual (remote link) and auto (obstacle-avoidance logic). Each command is a movement code plus a duration in ticks.
- Enforces a stopped dead-time before any change of motion, and an emergency-stop override.

---
 rtl/move_sequencer.sv | 168 ++++++++++++++++
 tb/tb_move_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Timed, arbitrated command sequencer in front of the movement FSM (manual beats auto).
// Define MOVE_PREEMPT_EN to let a manual command abort a running auto command.
module move_sequencer #(
  parameter int CLK_DIV   = 50000,
  parameter int DUR_W     = 16,
  parameter int GAP_TICKS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             estop,
  input  logic             man_valid,
  input  logic [3:0]       man_code,
  input  logic [DUR_W-1:0] man_dur,
  output logic             man_ready,
  input  logic             auto_valid,
  input  logic [3:0]       auto_code,
  input  logic [DUR_W-1:0] auto_dur,
  output logic             auto_ready,
  output logic [3:0]       movement_sel,
  output logic             busy,
  output logic [1:0]       owner,
  output logic             done,
  output logic             abort,
  output logic             err
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_RUN} state_t;

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic             tick;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_rem;
  logic [3:0]       last_code;
  logic [3:0]       cur_code;
  logic [DUR_W-1:0] rem;

  logic             man_fire;
  logic             auto_fire;
  logic             acc_fire;
  logic             preempt;
  logic [3:0]       acc_code;
  logic [DUR_W-1:0] acc_dur;
  logic [1:0]       acc_owner;
  logic [3:0]       eff_last;
  logic [GAP_W-1:0] eff_gap;

  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + 1'b1;
  end

`ifdef MOVE_PREEMPT_EN
  assign man_ready = !estop && ((state == S_IDLE) || ((state != S_IDLE) && (owner == 2'd2)));
  assign preempt   = man_fire && (state != S_IDLE);
`else
  assign man_ready = !estop && (state == S_IDLE);
  assign preempt   = 1'b0;
`endif

  assign auto_ready = !estop && (state == S_IDLE) && !man_valid;
  assign man_fire   = man_valid && man_ready;
  assign auto_fire  = auto_valid && auto_ready;
  assign acc_fire   = man_fire || auto_fire;
  assign acc_code   = man_fire ? man_code : auto_code;
  assign acc_dur    = man_fire ? man_dur : auto_dur;
  assign acc_owner  = man_fire ? 2'd1 : 2'd2;
  assign busy       = (state != S_IDLE);

  // A preempted auto run counts as the last motion and owes a full dead-time.
  assign eff_last = (preempt && (state == S_RUN) && (cur_code != 4'd0)) ? cur_code : last_code;
  assign eff_gap  = preempt ? '0 : gap_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      movement_sel <= 4'd0;
      owner        <= 2'd0;
      done         <= 1'b0;
      abort        <= 1'b0;
      err          <= 1'b0;
      gap_cnt      <= GAP_FULL;
      gap_rem      <= '0;
      last_code    <= 4'd0;
      cur_code     <= 4'd0;
      rem          <= '0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      err   <= 1'b0;
      if (tick && (movement_sel == 4'd0) && (gap_cnt < GAP_FULL))
        gap_cnt <= gap_cnt + 1'b1;

      if (estop) begin
        abort        <= (state != S_IDLE);
        state        <= S_IDLE;
        movement_sel <= 4'd0;
        owner        <= 2'd0;
        gap_cnt      <= '0;
      end else if (acc_fire) begin
        if (preempt) begin
          abort     <= 1'b1;
          last_code <= eff_last;
          gap_cnt   <= '0;
        end
        if (acc_code == 4'hF) begin
          err          <= 1'b1;
          state        <= S_IDLE;
          movement_sel <= 4'd0;
          owner        <= 2'd0;
        end else if (acc_dur == '0) begin
          done         <= 1'b1;
          state        <= S_IDLE;
          movement_sel <= 4'd0;
          owner        <= 2'd0;
        end else if ((acc_code != 4'd0) && (acc_code != eff_last) &&
                     (eff_last != 4'd0) && (eff_gap < GAP_FULL)) begin
          state        <= S_GAP;
          movement_sel <= 4'd0;
          owner        <= acc_owner;
          cur_code     <= acc_code;
          rem          <= acc_dur;
          gap_rem      <= GAP_FULL - eff_gap;
        end else begin
          state        <= S_RUN;
          movement_sel <= acc_code;
          owner        <= acc_owner;
          cur_code     <= acc_code;
          rem          <= acc_dur;
          if (acc_code != 4'd0) gap_cnt <= '0;
        end
      end else if (tick) begin
        case (state)
          S_GAP: begin
            if (gap_rem == GAP_W'(1)) begin
              state        <= S_RUN;
              movement_sel <= cur_code;
              gap_cnt      <= '0;
            end else begin
              gap_rem <= gap_rem - 1'b1;
            end
          end
          S_RUN: begin
            if (rem == DUR_W'(1)) begin
              state        <= S_IDLE;
              movement_sel <= 4'd0;
              owner        <= 2'd0;
              done         <= 1'b1;
              if (cur_code != 4'd0) last_code <= cur_code;
            end else begin
              rem <= rem - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer (CLK_DIV=4, GAP_TICKS=2, DUR_W=8); define
// MOVE_PREEMPT_EN for both bench and RTL to cover the preemption variant.
module tb_move_sequencer;

  localparam int CLK_DIV   = 4;
  localparam int DUR_W     = 8;
  localparam int GAP_TICKS = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             estop;
  logic             man_valid;
  logic [3:0]       man_code;
  logic [DUR_W-1:0] man_dur;
  logic             man_ready;
  logic             auto_valid;
  logic [3:0]       auto_code;
  logic [DUR_W-1:0] auto_dur;
  logic             auto_ready;
  logic [3:0]       movement_sel;
  logic             busy;
  logic [1:0]       owner;
  logic             done;
  logic             abort;
  logic             err;

  always #5 clk = ~clk;

  move_sequencer #(.CLK_DIV(CLK_DIV), .DUR_W(DUR_W), .GAP_TICKS(GAP_TICKS)) dut (
    .clk(clk), .rst(rst), .estop(estop),
    .man_valid(man_valid), .man_code(man_code), .man_dur(man_dur), .man_ready(man_ready),
    .auto_valid(auto_valid), .auto_code(auto_code), .auto_dur(auto_dur), .auto_ready(auto_ready),
    .movement_sel(movement_sel), .busy(busy), .owner(owner),
    .done(done), .abort(abort), .err(err)
  );

  typedef struct {
    bit         is_auto;
    logic [3:0] code;
    logic [7:0] dur;
    int         run_lo;
    int         run_hi;
    int         exp_done;
    int         exp_err;
    int         exp_owner;
  } vec_t;

  vec_t vecs [6];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; estop = 1'b0;
    man_valid = 1'b0; man_code = 4'd0; man_dur = '0;
    auto_valid = 1'b0; auto_code = 4'd0; auto_dur = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit is_auto, input logic [3:0] code, input logic [7:0] dur);
    if (is_auto) begin
      auto_valid = 1'b1; auto_code = code; auto_dur = dur;
    end else begin
      man_valid = 1'b1; man_code = code; man_dur = dur;
    end
  endtask

  // One command from idle: measure run length, dead-time, pulses and owner.
  task automatic run_single(input bit is_auto, input logic [3:0] code, input logic [7:0] dur,
                            output int run_cyc, output int zero_cyc, output int done_cnt,
                            output int err_cnt, output int own, output bit ok);
    int waited;
    run_cyc = 0; zero_cyc = 0; done_cnt = 0; err_cnt = 0; own = 0; ok = 1'b0; waited = 0;
    applyStimulus(is_auto, code, dur);
    while (!(is_auto ? auto_ready : man_ready) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    man_valid = 1'b0; auto_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy && movement_sel == code) begin
        run_cyc++;
        own = int'(owner);
      end else if (busy) begin
        zero_cyc++;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (!busy && (done_cnt + err_cnt) > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  endtask

  // Two commands in a row; drops each valid the cycle after it is accepted.
  task automatic watch_pair(input logic [3:0] c1, input logic [3:0] c2,
                            output int cyc1, output int cyc2, output int gap0,
                            output int dones, output int aborts, output int own1,
                            output int own2, output int ar_busy, output bit fin);
    bit seen1, seen2, pm, pa;
    seen1 = 1'b0; seen2 = 1'b0; pm = 1'b0; pa = 1'b0; fin = 1'b0;
    cyc1 = 0; cyc2 = 0; gap0 = 0; dones = 0; aborts = 0; own1 = 0; own2 = 0; ar_busy = 0;
    for (int i = 0; i < 300; i++) begin
      if (pm) man_valid = 1'b0;
      if (pa) auto_valid = 1'b0;
      pm = man_valid && man_ready;
      pa = auto_valid && auto_ready;
      if (busy && movement_sel == c1 && !seen2) begin
        cyc1++; seen1 = 1'b1; own1 = int'(owner);
      end else if (busy && movement_sel == c2 && seen1) begin
        cyc2++; seen2 = 1'b1; own2 = int'(owner);
      end else if (seen1 && !seen2 && movement_sel == 4'd0) begin
        gap0++;
      end
      if (done) dones++;
      if (abort) aborts++;
      if (busy && auto_ready) ar_busy++;
      if (seen2 && !busy) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int run_cyc, zero_cyc, done_cnt, err_cnt, own, cnt, dn, ab;
    int c1, c2, g0, o1, o2, arb;
    bit ok, fin;

    vecs[0] = '{1'b0, 4'h1, 8'd3, 9, 12, 1, 0, 1};
    vecs[1] = '{1'b1, 4'h4, 8'd2, 5, 8, 1, 0, 2};
    vecs[2] = '{1'b0, 4'hF, 8'd5, 0, 0, 0, 1, 0};
    vecs[3] = '{1'b0, 4'h6, 8'd0, 0, 0, 1, 0, 0};
    vecs[4] = '{1'b1, 4'h0, 8'd2, 5, 8, 1, 0, 2};
    vecs[5] = '{1'b0, 4'h7, 8'd1, 1, 4, 1, 0, 1};

    do_reset();
    checkOutput("reset_sel", int'(movement_sel), 0);
    checkOutput("reset_owner", int'(owner), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_pulses", int'({done, abort, err}), 0);
    checkOutput("reset_man_ready", int'(man_ready), 1);
    checkOutput("reset_auto_ready", int'(auto_ready), 1);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_single(vecs[v].is_auto, vecs[v].code, vecs[v].dur,
                 run_cyc, zero_cyc, done_cnt, err_cnt, own, ok);
      check_range($sformatf("vec%0d_run_cycles", v), run_cyc, vecs[v].run_lo, vecs[v].run_hi);
      checkOutput($sformatf("vec%0d_done_pulses", v), done_cnt, vecs[v].exp_done);
      checkOutput($sformatf("vec%0d_err_pulses", v), err_cnt, vecs[v].exp_err);
      checkOutput($sformatf("vec%0d_owner", v), own, vecs[v].exp_owner);
      checkOutput($sformatf("vec%0d_gap_cycles", v), zero_cyc, 0);
      checkOutput($sformatf("vec%0d_completed", v), int'(ok), 1);
      checkOutput($sformatf("vec%0d_idle_sel_owner", v), int'({movement_sel, owner, busy}), 0);
    end

    // Different code right after done: one IDLE cycle plus gap = two full ticks at 0.
    do_reset();
    applyStimulus(1'b0, 4'h1, 8'd2);
    @(negedge clk);
    man_code = 4'h2; man_dur = 8'd1;
    watch_pair(4'h1, 4'h2, c1, c2, g0, dn, ab, o1, o2, arb, fin);
    check_range("gap_run1_cycles", c1, 5, 8);
    checkOutput("gap_zero_cycles", g0, 8);
    checkOutput("gap_run2_cycles", c2, 4);
    checkOutput("gap_done_pulses", dn, 2);
    checkOutput("gap_abort_pulses", ab, 0);
    checkOutput("gap_owner2", o2, 1);
    checkOutput("gap_finished", int'(fin), 1);

    // Simultaneous requests: manual wins, auto waits and then gaps.
    do_reset();
    applyStimulus(1'b0, 4'h3, 8'd1);
    applyStimulus(1'b1, 4'h4, 8'd1);
    #1;
    checkOutput("arb_man_ready", int'(man_ready), 1);
    checkOutput("arb_auto_ready", int'(auto_ready), 0);
    @(negedge clk);
    man_valid = 1'b0;
    watch_pair(4'h3, 4'h4, c1, c2, g0, dn, ab, o1, o2, arb, fin);
    checkOutput("arb_owner_manual", o1, 1);
    checkOutput("arb_owner_auto", o2, 2);
    checkOutput("arb_auto_ready_while_busy", arb, 0);
    check_range("arb_run1_cycles", c1, 1, 4);
    checkOutput("arb_gap_cycles", g0, 8);
    checkOutput("arb_run2_cycles", c2, 4);
    checkOutput("arb_done_pulses", dn, 2);
    checkOutput("arb_finished", int'(fin), 1);

    // Emergency stop while idle and while running; gap owed in full afterwards.
    do_reset();
    run_single(1'b0, 4'h1, 8'd1, run_cyc, zero_cyc, done_cnt, err_cnt, own, ok);
    checkOutput("estop_pre_done", done_cnt, 1);
    repeat (16) @(negedge clk);
    estop = 1'b1;
    @(negedge clk);
    checkOutput("estop_idle_no_abort", int'(abort), 0);
    checkOutput("estop_man_ready_low", int'(man_ready), 0);
    checkOutput("estop_auto_ready_low", int'(auto_ready), 0);
    estop = 1'b0;
    applyStimulus(1'b0, 4'h5, 8'd3);
    @(negedge clk);
    man_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && movement_sel != 4'h5; i++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    check_range("estop_idle_gap_cycles", cnt, 5, 8);
    repeat (2) @(negedge clk);
    checkOutput("estop_running_sel", int'(movement_sel), 5);
    estop = 1'b1;
    @(negedge clk);
    checkOutput("estop_run_sel", int'(movement_sel), 0);
    checkOutput("estop_run_abort", int'(abort), 1);
    checkOutput("estop_run_done", int'(done), 0);
    checkOutput("estop_run_busy_owner", int'({busy, owner}), 0);
    checkOutput("estop_run_man_ready", int'(man_ready), 0);
    estop = 1'b0;
    applyStimulus(1'b0, 4'h5, 8'd1);
    @(negedge clk);
    man_valid = 1'b0;
    checkOutput("estop_abort_one_cycle", int'(abort), 0);
    cnt = 0;
    for (int i = 0; i < 40 && movement_sel != 4'h5; i++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    check_range("estop_rerun_gap_cycles", cnt, 5, 8);
    dn = 0; ab = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      if (abort) ab++;
      if (!busy && dn > 0) break;
      @(negedge clk);
    end
    checkOutput("estop_rerun_done", dn, 1);
    checkOutput("estop_rerun_abort", ab, 0);

    // Manual command arriving while auto code 1 is running.
    do_reset();
    applyStimulus(1'b1, 4'h1, 8'd5);
    @(negedge clk);
    auto_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_auto_sel", int'(movement_sel), 1);
    checkOutput("pre_auto_owner", int'(owner), 2);
    applyStimulus(1'b0, 4'h2, 8'd1);
`ifdef MOVE_PREEMPT_EN
    checkOutput("pre_man_ready", int'(man_ready), 1);
    @(negedge clk);
    man_valid = 1'b0;
    checkOutput("pre_abort", int'(abort), 1);
    checkOutput("pre_gap_sel", int'(movement_sel), 0);
    checkOutput("pre_gap_busy", int'(busy), 1);
    cnt = 0;
    for (int i = 0; i < 40 && movement_sel != 4'h2; i++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    check_range("pre_gap_cycles", cnt, 5, 8);
    checkOutput("pre_owner_manual", int'(owner), 1);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      if (!busy && dn > 0) break;
      @(negedge clk);
    end
    checkOutput("pre_done_pulses", dn, 1);
`else
    checkOutput("pre_man_ready", int'(man_ready), 0);
    watch_pair(4'h1, 4'h2, c1, c2, g0, dn, ab, o1, o2, arb, fin);
    check_range("pre_auto_full_run", c1 + 2, 17, 20);
    checkOutput("pre_abort_pulses", ab, 0);
    checkOutput("pre_done_pulses", dn, 2);
    checkOutput("pre_gap_cycles", g0, 8);
    checkOutput("pre_owner_manual", o2, 1);
    checkOutput("pre_finished", int'(fin), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
